// File: rtl/vec_mem_seq.sv
// vec_mem_seq -- vector load/store element sequencer.
// Moves up to LANES elements of LANE_W bits between a vector register and a
// word memory, one element per clock, with a start/busy/done handshake.
// Loads are pipelined: one read address per cycle, and data returns one cycle
// after its address.
// Optional feature: define VMS_STRIDE_EN to add the stride port. Without it,
// addressing is contiguous (base + idx).
module vec_mem_seq #(
  parameter  int LANES  = 16,
  parameter  int LANE_W = 16,
  parameter  int ADDR_W = 16,
  localparam int CW     = $clog2(LANES)
) (
  input  logic                    Clk1,
  input  logic                    Reset,
  input  logic                    start,
  input  logic                    is_store,
  input  logic [ADDR_W-1:0]       base_addr,
`ifdef VMS_STRIDE_EN
  input  logic [ADDR_W-1:0]       stride,
`endif
  input  logic [CW-1:0]           count,
  input  logic [LANES*LANE_W-1:0] st_vec,
  input  logic [LANE_W-1:0]       DataIn,
  output logic                    busy,
  output logic                    done,
  output logic [LANES*LANE_W-1:0] ld_vec,
  output logic [ADDR_W-1:0]       Addr,
  output logic                    RD,
  output logic                    WR,
  output logic [LANE_W-1:0]       dataOut
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_STORE
  } state_t;

  state_t state_q, state_d;

  // Transfer parameters captured on an accepted start.
  logic [CW-1:0]     count_q;
  // Lane 0 goes straight from st_vec to dataOut on the accept edge, so only
  // lanes 1 and up need to be held for the rest of the store.
  logic [LANES-1:1][LANE_W-1:0] st_q;
  logic [ADDR_W-1:0] step;

  // Element index of the address currently on Addr.
  logic [CW-1:0] idx_q;
  logic [CW-1:0] idx_nxt;

  // A read issued last cycle whose data is on DataIn this cycle.
  logic          cap_vld_q;
  logic [CW-1:0] cap_idx_q;

  logic [LANES-1:0][LANE_W-1:0] ld_q;

  logic accept;
  logic last;
  logic advance;

  // Next-cycle values of the registered handshake/strobe outputs.
  logic rd_d;
  logic wr_d;
  logic busy_d;
  logic done_d;

  assign accept  = (state_q == S_IDLE) && start;
  assign last    = (idx_q == count_q);
  assign advance = ((state_q == S_LOAD) || (state_q == S_STORE)) && !last;
  assign idx_nxt = idx_q + CW'(1);
  assign ld_vec  = ld_q;

`ifdef VMS_STRIDE_EN
  logic [ADDR_W-1:0] stride_q;

  // Capture the per-element increment with the other transfer parameters.
  always_ff @(posedge Clk1) begin
    if (accept) begin
      stride_q <= stride;
    end
  end

  assign step = stride_q;
`else
  // Contiguous addressing: the address path is a plain incrementer.
  assign step = ADDR_W'(1);
`endif

  // State register.
  always_ff @(posedge Clk1) begin
    // NOTE: every clocked assignment uses <= so all registers update from
    // the same pre-edge values, independent of statement order.
    if (Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start only matters in IDLE; the last element ends the
  // load (through DRAIN) or the store (straight back to IDLE).
  always_comb begin
    // NOTE: defaulting state_d before the case keeps every path assigned, so
    // no latch is inferred.
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = is_store ? S_STORE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (last) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        state_d = S_IDLE;
      end
      S_STORE: begin
        if (last) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode: strobes follow the state being entered so that the
  // registered outputs line up with it; done marks the return to IDLE.
  always_comb begin
    rd_d   = (state_d == S_LOAD);
    wr_d   = (state_d == S_STORE);
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_DRAIN) || ((state_q == S_STORE) && last);
  end

  // Parameter capture; these registers are only meaningful after an accept.
  always_ff @(posedge Clk1) begin
    // NOTE: count_q and st_q are deliberately left out of reset: they are
    // always written on accept before they are read, so a reset would only
    // add fan-out on Reset.
    if (accept) begin
      count_q <= count;
      if (is_store) begin
        st_q <= st_vec[LANES*LANE_W-1:LANE_W];
      end
    end
  end

  // Registered outputs, element index, address generation and load capture.
  always_ff @(posedge Clk1) begin
    if (Reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      RD        <= 1'b0;
      WR        <= 1'b0;
      Addr      <= '0;
      dataOut   <= '0;
      idx_q     <= '0;
      cap_vld_q <= 1'b0;
      cap_idx_q <= '0;
      ld_q      <= '0;
    end else begin
      busy <= busy_d;
      done <= done_d;
      RD   <= rd_d;
      WR   <= wr_d;

      // Running address: base on accept, plus one step per element. The sum
      // wraps modulo 2^ADDR_W, which is the intended address arithmetic.
      if (accept) begin
        idx_q <= '0;
        Addr  <= base_addr;
      end else if (advance) begin
        idx_q <= idx_nxt;
        Addr  <= Addr + step;
      end

      // Store data tracks the element being addressed.
      if (accept && is_store) begin
        dataOut <= st_vec[LANE_W-1:0];
      end else if ((state_q == S_STORE) && !last) begin
        dataOut <= st_q[idx_nxt];
      end

      // Remember which lane the read issued this cycle belongs to.
      cap_vld_q <= (state_q == S_LOAD);
      cap_idx_q <= idx_q;

      if (cap_vld_q) begin
        ld_q[cap_idx_q] <= DataIn;
      end
      // A new load starts from an all-zero vector so unused lanes read as 0.
      if (accept && !is_store) begin
        ld_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vec_mem_seq.sv
// Self-checking bench for vec_mem_seq. A word memory model answers reads one
// cycle after the address; expected addresses, lane contents and handshake
// timing come from the transfer rules (base + i*stride, lanes above count
// zero, done at N+2 / N+1).
module tb_vec_mem_seq;

  localparam int LANES  = 16;
  localparam int LANE_W = 16;
  localparam int ADDR_W = 16;
  localparam int CW     = 4;
  localparam int VW     = LANES * LANE_W;

  logic              Clk1 = 1'b0;
  logic              Reset;
  logic              start;
  logic              is_store;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] stride;
  logic [CW-1:0]     count;
  logic [VW-1:0]     st_vec;
  logic [LANE_W-1:0] DataIn = '0;

  wire               busy;
  wire               done;
  wire  [VW-1:0]     ld_vec;
  wire  [ADDR_W-1:0] Addr;
  wire               RD;
  wire               WR;
  wire  [LANE_W-1:0] dataOut;

  int total = 0;
  int bad   = 0;

  logic [15:0]   key;
  logic [VW-1:0] ld_model;

  int rd_seen    = 0;
  int wr_seen    = 0;
  int done_seen  = 0;
  int clash_seen = 0;

  always #5 Clk1 = ~Clk1;

  vec_mem_seq #(
    .LANES  (LANES),
    .LANE_W (LANE_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .Clk1      (Clk1),
    .Reset     (Reset),
    .start     (start),
    .is_store  (is_store),
    .base_addr (base_addr),
`ifdef VMS_STRIDE_EN
    .stride    (stride),
`endif
    .count     (count),
    .st_vec    (st_vec),
    .DataIn    (DataIn),
    .busy      (busy),
    .done      (done),
    .ld_vec    (ld_vec),
    .Addr      (Addr),
    .RD        (RD),
    .WR        (WR),
    .dataOut   (dataOut)
  );

  // Memory contents are a function of the address: mem[a] = a ^ key.
  function automatic logic [15:0] mem_at(input logic [15:0] a);
    return a ^ key;
  endfunction

  // Synchronous-read memory: data for the address of cycle k is on DataIn in k+1.
  always @(posedge Clk1) begin
    if (RD) begin
      DataIn <= mem_at(Addr);
    end
  end

  // Event counters sampled mid-cycle.
  always @(negedge Clk1) begin
    if (RD)        rd_seen++;
    if (WR)        wr_seen++;
    if (done)      done_seen++;
    if (RD && WR)  clash_seen++;
  end

  function automatic logic [15:0] elem_addr(input logic [15:0] base,
                                            input logic [15:0] strd,
                                            input int          i);
    logic [31:0] s;
    s = 32'(base) + 32'(i) * 32'(strd);
    return s[15:0];
  endfunction

  task automatic check(input string tag, input logic [VW-1:0] obs,
                       input logic [VW-1:0] req);
    total++;
    assert (obs === req) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int l = 0; l < LANES; l++) v[l*LANE_W +: LANE_W] = 16'($urandom);
    return v;
  endfunction

  // Called at a negedge; start is raised here and the task returns at the
  // negedge of the done cycle, so a following call is back-to-back.
  task automatic do_load(input string tag, input logic [15:0] base,
                         input logic [15:0] strd, input int cnt);
    logic [VW-1:0] expv;
    logic [15:0]   a;
    expv      = '0;
    start     = 1'b1;
    is_store  = 1'b0;
    base_addr = base;
    stride    = strd;
    count     = CW'(cnt);
    @(negedge Clk1);
    start     = 1'b0;
    base_addr = ~base;
    stride    = ~strd;
    count     = ~CW'(cnt);
    for (int c = 1; c <= cnt + 1; c++) begin
      a = elem_addr(base, strd, c - 1);
      check({tag, "_flags_rd"}, VW'({busy, done, RD, WR}), VW'(4'b1010));
      check({tag, "_addr"}, VW'(Addr), VW'(a));
      expv[(c-1)*LANE_W +: LANE_W] = mem_at(a);
      @(negedge Clk1);
    end
    check({tag, "_flags_drain"}, VW'({busy, done, RD, WR}), VW'(4'b1000));
    @(negedge Clk1);
    check({tag, "_flags_done"}, VW'({busy, done, RD, WR}), VW'(4'b0100));
    check({tag, "_ld_vec"}, ld_vec, expv);
    ld_model = expv;
  endtask

  task automatic do_store(input string tag, input logic [15:0] base,
                          input logic [15:0] strd, input int cnt,
                          input logic [VW-1:0] sv, input bit poke);
    start     = 1'b1;
    is_store  = 1'b1;
    base_addr = base;
    stride    = strd;
    count     = CW'(cnt);
    st_vec    = sv;
    @(negedge Clk1);
    start     = 1'b0;
    base_addr = ~base;
    stride    = ~strd;
    count     = ~CW'(cnt);
    st_vec    = ~sv;
    for (int c = 1; c <= cnt + 1; c++) begin
      check({tag, "_flags_wr"}, VW'({busy, done, RD, WR}), VW'(4'b1001));
      check({tag, "_addr"}, VW'(Addr), VW'(elem_addr(base, strd, c - 1)));
      check({tag, "_data"}, VW'(dataOut), VW'(sv[(c-1)*LANE_W +: LANE_W]));
      if (poke && c == 3) begin
        start    = 1'b1;
        is_store = 1'b0;
      end
      if (poke && c == 4) start = 1'b0;
      @(negedge Clk1);
    end
    check({tag, "_flags_done"}, VW'({busy, done, RD, WR}), VW'(4'b0100));
    check({tag, "_ld_kept"}, ld_vec, ld_model);
  endtask

  initial begin
    logic [VW-1:0] sv;
    logic [15:0]   b;
    logic [15:0]   s;
    int            n;
    int            r0;
    int            w0;
    int            d0;

    Reset     = 1'b1;
    start     = 1'b0;
    is_store  = 1'b0;
    base_addr = '0;
    stride    = '0;
    count     = '0;
    st_vec    = '0;
    key       = 16'hA5A5;
    ld_model  = '0;
    repeat (3) @(negedge Clk1);
    check("reset_flags", VW'({busy, done, RD, WR}), VW'(4'b0000));
    check("reset_addr", VW'(Addr), VW'(0));
    check("reset_dout", VW'(dataOut), VW'(0));
    check("reset_ld_vec", ld_vec, '0);
    Reset = 1'b0;
    @(negedge Clk1);

    // Contiguous full-length load.
    do_load("ld_contig", 16'h0040, 16'd1, 15);
    @(negedge Clk1);
    check("ld_contig_single_done", VW'({busy, done, RD, WR}), VW'(4'b0000));

    // Partial store; Addr and dataOut hold their last values afterwards.
    sv = '0;
    sv[63:0] = 64'h4444_3333_2222_1111;
    do_store("st_partial", 16'h0100, 16'd1, 3, sv, 1'b0);
    @(negedge Clk1);
    check("st_partial_idle_flags", VW'({busy, done, RD, WR}), VW'(4'b0000));
    check("st_partial_addr_hold", VW'(Addr), VW'(16'h0103));
    check("st_partial_dout_hold", VW'(dataOut), VW'(16'h4444));

`ifdef VMS_STRIDE_EN
    // Strided load that wraps past the top of the address space.
    do_load("ld_wrap", 16'hFFFE, 16'd3, 2);
    @(negedge Clk1);
    do_load("ld_stride0", 16'h1234, 16'd0, 4);
    @(negedge Clk1);
`endif

    // Back-to-back: load -> store -> load with no idle cycles.
    key = 16'h5A3C;
    do_load("b2b_ld", 16'h2000, 16'd1, 5);
    do_store("b2b_st", 16'h2100, 16'd1, 9, rand_vec(), 1'b0);
    do_load("b2b_ld_cnt0", 16'h2200, 16'd1, 0);
    @(negedge Clk1);

    // start pulsed while a store is running is ignored.
    r0 = rd_seen;
    w0 = wr_seen;
    d0 = done_seen;
    do_store("busy_start", 16'h0300, 16'd1, 7, rand_vec(), 1'b1);
    repeat (2) @(negedge Clk1);
    check("busy_start_wr_cycles", VW'(wr_seen - w0), VW'(8));
    check("busy_start_done_pulses", VW'(done_seen - d0), VW'(1));
    check("busy_start_no_rd", VW'(rd_seen - r0), VW'(0));

    // Reset in cycle 5 of a full-length load.
    key       = 16'hA5A5;
    d0        = done_seen;
    start     = 1'b1;
    is_store  = 1'b0;
    base_addr = 16'h0500;
    stride    = 16'd1;
    count     = 4'd15;
    @(negedge Clk1);
    start = 1'b0;
    repeat (4) @(negedge Clk1);
    check("rst_mid_rd_before", VW'({busy, RD}), VW'(2'b11));
    Reset = 1'b1;
    @(negedge Clk1);
    check("rst_mid_flags", VW'({busy, done, RD, WR}), VW'(4'b0000));
    check("rst_mid_ld_vec", ld_vec, '0);
    check("rst_mid_addr", VW'(Addr), VW'(0));
    Reset    = 1'b0;
    ld_model = '0;
    repeat (20) @(negedge Clk1);
    check("rst_mid_no_done", VW'(done_seen - d0), VW'(0));
    check("rst_mid_idle", VW'(busy), VW'(0));

    // Randomised mix of loads and stores, sometimes back-to-back.
    for (int t = 0; t < 16; t++) begin
      key = 16'($urandom);
      b   = 16'($urandom);
      n   = $urandom_range(0, 15);
`ifdef VMS_STRIDE_EN
      s   = 16'($urandom_range(0, 40));
`else
      s   = 16'd1;
`endif
      if ($urandom_range(0, 1) == 1) begin
        do_load("rnd_ld", b, s, n);
      end else begin
        do_store("rnd_st", b, s, n, rand_vec(), 1'b0);
      end
      if ($urandom_range(0, 1) == 1) @(negedge Clk1);
    end
    repeat (2) @(negedge Clk1);
    check("never_rd_and_wr", VW'(clash_seen), VW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
